// File: rtl/reg_writeback_unit_pkg.sv
// Shared RISC-V register definitions for the writeback slice: widths, x0 index and queue entry.
// Build option WB_BYPASS_EN (used by reg_writeback_unit) enables the pending-write bypass search.
package reg_writeback_unit_pkg;

  localparam int RV_ADDR_W = 5;
  localparam int RV_DATA_W = 32;
  localparam logic [RV_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [RV_ADDR_W-1:0] rd;
    logic [RV_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_unit_wb_fifo.sv
// Circular writeback queue: up to two pushes (push_a older than push_b) and one pop per cycle.
// The storage array is exported so the top level can search pending writes.
module reg_writeback_unit_wb_fifo
  import reg_writeback_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       push_cnt,
  input  wb_entry_t        push_a,
  input  wb_entry_t        push_b,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic [PTR_W-1:0] rd_ptr,
  output wb_entry_t        entries [DEPTH]
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_next;
  logic             pop_eff;

  assign wr_ptr_next = wr_ptr + PTR_W'(1);
  assign pop_eff     = pop && (count != '0);
  assign head        = entries[rd_ptr];

  // Storage is not reset; clearing the pointers is enough to discard stale entries.
  always_ff @(posedge CLK) begin
    if (push_cnt != 2'd0) entries[wr_ptr] <= push_a;
    if (push_cnt == 2'd2) entries[wr_ptr_next] <= push_b;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_cnt);
      rd_ptr <= rd_ptr + PTR_W'(pop_eff);
      count  <= count + CNT_W'(push_cnt) - CNT_W'(pop_eff);
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// In-order writeback queue feeding the register_file write port, one write per cycle.
// Define WB_BYPASS_EN to enable youngest-match lookup of pending writes on RS1/RS2.
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = RV_ADDR_W,
  parameter int DATA_W = RV_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ALU_VALID,
  input  logic [ADDR_W-1:0] ALU_RD,
  input  logic [DATA_W-1:0] ALU_DATA,
  input  logic              LD_VALID,
  input  logic [ADDR_W-1:0] LD_RD,
  input  logic [DATA_W-1:0] LD_DATA,
  output logic              STALL,
  output logic              WRITE_ENABLE,
  output logic [ADDR_W-1:0] WRITE_REG,
  output logic [DATA_W-1:0] WRITE_DATA,
  input  logic [ADDR_W-1:0] RS1_ADDR,
  input  logic [ADDR_W-1:0] RS2_ADDR,
  output logic              BYP1_HIT,
  output logic [DATA_W-1:0] BYP1_DATA,
  output logic              BYP2_HIT,
  output logic [DATA_W-1:0] BYP2_DATA
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             ld_acc;
  logic             alu_acc;
  logic [1:0]       push_cnt;
  logic             write_en;
  wb_entry_t        push_a;
  wb_entry_t        push_b;
  wb_entry_t        head;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  wb_entry_t        entries [DEPTH];

  // Two free slots are needed because both sources may arrive together.
  assign STALL    = count > CNT_W'(DEPTH - 2);
  assign ld_acc   = LD_VALID && (LD_RD != REG_ZERO) && !STALL;
  assign alu_acc  = ALU_VALID && (ALU_RD != REG_ZERO) && !STALL;
  assign push_cnt = {1'b0, ld_acc} + {1'b0, alu_acc};

  // Compact accepted results so the older one (load) always lands in the first slot.
  always_comb begin
    push_b.rd   = ALU_RD;
    push_b.data = ALU_DATA;
    if (ld_acc) begin
      push_a.rd   = LD_RD;
      push_a.data = LD_DATA;
    end else begin
      push_a = push_b;
    end
  end

  reg_writeback_unit_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_cnt(push_cnt),
    .push_a  (push_a),
    .push_b  (push_b),
    .pop     (write_en),
    .head    (head),
    .count   (count),
    .rd_ptr  (rd_ptr),
    .entries (entries)
  );

  assign write_en     = count != '0;
  assign WRITE_ENABLE = write_en;
  assign WRITE_REG    = write_en ? head.rd : '0;
  assign WRITE_DATA   = write_en ? head.data : '0;

`ifdef WB_BYPASS_EN
  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    BYP1_HIT  = 1'b0;
    BYP1_DATA = '0;
    BYP2_HIT  = 1'b0;
    BYP2_DATA = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if ((RS1_ADDR != REG_ZERO) && (entries[idx].rd == RS1_ADDR)) begin
          BYP1_HIT  = 1'b1;
          BYP1_DATA = entries[idx].data;
        end
        if ((RS2_ADDR != REG_ZERO) && (entries[idx].rd == RS2_ADDR)) begin
          BYP2_HIT  = 1'b1;
          BYP2_DATA = entries[idx].data;
        end
      end
    end
  end
`else
  logic unused_bypass;

  always_comb begin
    unused_bypass = ^{RS1_ADDR, RS2_ADDR, rd_ptr};
    for (int k = 0; k < DEPTH; k++) begin
      unused_bypass = unused_bypass ^ (^entries[k]);
    end
  end

  assign BYP1_HIT  = 1'b0;
  assign BYP1_DATA = '0;
  assign BYP2_HIT  = 1'b0;
  assign BYP2_DATA = '0;
`endif

endmodule
